// File: rtl/cnn_mem_pkg.sv
// Shared definitions for the memory stream reader: FSM state encoding,
// default bus widths and word geometry.
package cnn_mem_pkg;

  // Byte-address width of the data memory (1 KiB).
  localparam int DEF_ADDR_W = 10;
  // Word-count width; 256 words covers the whole memory.
  localparam int DEF_CNT_W  = 9;
  // Memory word geometry.
  localparam int WORD_W     = 32;
  localparam int WORD_BYTES = 4;

  // Reader control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/mem_stream_reader_if.sv
// Memory read port and output stream of the reader, bundled together.
// The master side issues reads and drives the stream; the slave side is
// the memory plus the stream consumer.
interface mem_stream_reader_if
  import cnn_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic [WORD_W-1:0] mem_readdata;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;

  modport master (
    output mem_address,
    output mem_read,
    input  mem_readdata,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    output mem_readdata,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/stream_fifo2.sv
// Two-entry FIFO between the memory read port and the output stream.
// A push is accepted while full only when the head is popped in the same
// cycle, which is what lets the reader sustain one word per cycle.
module stream_fifo2
  import cnn_mem_pkg::*;
#(
  parameter int W = WORD_W + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;
  logic         do_push;
  logic         do_pop;
  logic [W-1:0] slot_data [2];

  assign full    = (count_reg == 2'd2);
  assign empty   = (count_reg == 2'd0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [W-1:0] data_reg;

      // Slot storage; cleared on reset so the stream data reads as zero.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          data_reg <= '0;
        end else if (do_push && (int'(wr_ptr_reg) == gi)) begin
          data_reg <= din;
        end
      end

      assign slot_data[gi] = data_reg;
    end
  endgenerate

  assign dout = slot_data[rd_ptr_reg];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/mem_stream_reader.sv
// Burst reader: on start, reads word_count consecutive 32-bit words from a
// combinational-read data memory and streams them out through a 2-entry
// FIFO with valid/ready handshake, tagging the final word with out_last.
module mem_stream_reader
  import cnn_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    word_count,
  output logic                busy,
  output logic                done,
  mem_stream_reader_if.master bus
);

  localparam int ENTRY_W = WORD_W + 1;

  rd_state_t         state_reg;
  rd_state_t         state_next;
  // Address of the next word to be read.
  logic [ADDR_W-1:0] next_addr_reg;
  // Address of the most recent read; presented while no read is issued.
  logic [ADDR_W-1:0] last_addr_reg;
  // Words still to be read in the current burst.
  logic [CNT_W-1:0]  remain_reg;

  logic               accept;
  logic               rd_en;
  logic               last_word;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;

  // The word being read now is the final one when exactly one remains.
  assign last_word = (remain_reg == CNT_W'(1));

  assign fifo_pop  = bus.out_valid & bus.out_ready;
  assign fifo_push = rd_en;
  assign fifo_din  = {last_word, bus.mem_readdata};

  // Next-state, read-enable and completion decode.
  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    accept     = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (word_count == '0) ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Read only when the fetched word has somewhere to land.
        rd_en = ~fifo_full | fifo_pop;
        if (rd_en && last_word) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Everything has been handed off: this is the completion cycle.
        // busy is already low here, so a new start is honoured.
        if (fifo_empty) begin
          done       = 1'b1;
          state_next = ST_IDLE;
          if (start) begin
            accept     = 1'b1;
            state_next = (word_count == '0) ? ST_DRAIN : ST_FETCH;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_reg != ST_IDLE) & ~done;

  // Control state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Burst capture and per-read address/count advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_addr_reg <= '0;
      last_addr_reg <= '0;
      remain_reg    <= '0;
    end else if (accept) begin
      // Force word alignment of the captured base.
      next_addr_reg <= {base_addr[ADDR_W-1:2], 2'b00};
      remain_reg    <= word_count;
    end else if (rd_en) begin
      // Address arithmetic wraps naturally at the top of memory.
      last_addr_reg <= next_addr_reg;
      next_addr_reg <= next_addr_reg + ADDR_W'(WORD_BYTES);
      remain_reg    <= remain_reg - CNT_W'(1);
    end
  end

  assign bus.mem_read    = rd_en;
  assign bus.mem_address = rd_en ? next_addr_reg : last_addr_reg;

  stream_fifo2 #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.out_valid = ~fifo_empty;
  assign bus.out_data  = fifo_dout[WORD_W-1:0];
  assign bus.out_last  = ~fifo_empty & fifo_dout[WORD_W];

endmodule

// File: tb/tb_mem_stream_reader.sv
// Testbench for mem_stream_reader: directed bursts plus randomized bursts
// under random back-pressure, checked against a simple address/data model.
module tb_mem_stream_reader;
  import cnn_mem_pkg::*;

  localparam int ADDR_W   = 10;
  localparam int CNT_W    = 9;
  localparam int MEM_SIZE = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  word_count = '0;
  logic              busy;
  logic              done;

  mem_stream_reader_if #(.ADDR_W(ADDR_W)) bus ();

  mem_stream_reader #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  // Data memory: combinational read.
  logic [31:0] mem_words [MEM_SIZE/4];
  assign bus.mem_readdata = mem_words[bus.mem_address[ADDR_W-1:2]];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_mode = 0;
  int rdy_idx    = 0;

  // Observations gathered by the monitor.
  logic [31:0]       obs_data [$];
  bit                obs_last [$];
  int                obs_cyc  [$];
  logic [ADDR_W-1:0] obs_addr [$];
  int                read_cyc [$];
  int                done_cyc [$];
  int                start_cyc;
  int                stall_viol;
  int                full_read_viol;
  int                done_busy_viol;
  int                valid_cnt;
  int                occ;
  bit                xfer;
  bit                prev_stall;
  logic [31:0]       prev_data;
  logic              prev_last;

  // Model expectations.
  logic [31:0]       exp_data [$];
  bit                exp_last [$];
  logic [ADDR_W-1:0] exp_addr [$];

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Consumer ready pattern.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ((rdy_idx % 3) == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      rdy_idx++;
    end
  end

  // Monitor, sampling mid-cycle on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      occ        = 0;
      prev_stall = 1'b0;
    end else begin
      xfer = bus.out_valid && bus.out_ready;
      if (start && !busy) start_cyc = cyc;
      if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data ||
                         bus.out_last !== prev_last)) stall_viol++;
      if (bus.mem_read && occ >= 2 && !xfer) full_read_viol++;
      if (bus.out_valid) valid_cnt++;
      if (xfer) begin
        obs_data.push_back(bus.out_data);
        obs_last.push_back(bus.out_last);
        obs_cyc.push_back(cyc);
      end
      if (bus.mem_read) begin
        obs_addr.push_back(bus.mem_address);
        read_cyc.push_back(cyc);
      end
      if (done) begin
        done_cyc.push_back(cyc);
        if (busy) done_busy_viol++;
      end
      occ = occ + (bus.mem_read ? 1 : 0) - (xfer ? 1 : 0);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_last.delete();
    obs_cyc.delete();
    obs_addr.delete();
    read_cyc.delete();
    done_cyc.delete();
    start_cyc      = -1;
    stall_viol     = 0;
    full_read_viol = 0;
    done_busy_viol = 0;
    valid_cnt      = 0;
  endtask

  // Reference: word i lives at aligned base + 4*i, wrapping around memory.
  task automatic build_expected(input int base, input int count);
    exp_data.delete();
    exp_last.delete();
    exp_addr.delete();
    for (int i = 0; i < count; i++) begin
      int a;
      a = ((base & ~3) + 4 * i) % MEM_SIZE;
      exp_addr.push_back(ADDR_W'(a));
      exp_data.push_back(mem_words[a / 4]);
      exp_last.push_back(i == count - 1);
    end
  endtask

  task automatic pulse_start(input int base, input int count);
    base_addr  = ADDR_W'(base);
    word_count = CNT_W'(count);
    start      = 1'b1;
    wait_cycle();
    start      = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done_cyc.size() > 0) begin
        ok = 1'b1;
        break;
      end
      wait_cycle();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, bus.mem_read, bus.out_valid, bus.out_last} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {busy, done, bus.mem_read, bus.out_valid, bus.out_last});
    end
    n_checks++;
    if (bus.mem_address !== '0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h expected 000", bus.mem_address);
    end
    n_checks++;
    if (bus.out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 00000000", bus.out_data);
    end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_cycle();
    n_checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b valid=%b read=%b expected 0 0 0",
               busy, bus.out_valid, bus.mem_read);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic_burst();
    bit ok;
    ready_mode = 0;
    clear_obs();
    build_expected(32'h100, 4);
    pulse_start(32'h100, 4);
    wait_done(ok);
    wait_cycle();
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_done_timeout: got no done expected done");
    end
    n_checks++;
    if (obs_data.size() !== 4) begin
      n_fail++;
      $display("FAIL basic_count: got %0d expected 4", obs_data.size());
    end
    for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== 32'h11111111 * (i + 1) || obs_last[i] !== (i == 3) ||
          obs_cyc[i] !== start_cyc + 2 + i) begin
        n_fail++;
        $display("FAIL basic_word%0d: got %h last=%b cyc=%0d expected %h last=%b cyc=%0d",
                 i, obs_data[i], obs_last[i], obs_cyc[i], 32'h11111111 * (i + 1),
                 (i == 3), start_cyc + 2 + i);
      end
    end
    n_checks++;
    if (read_cyc.size() == 0 || read_cyc[0] !== start_cyc + 1 || obs_addr[0] !== 10'h100) begin
      n_fail++;
      $display("FAIL basic_first_read: got n=%0d cyc=%0d expected cyc=%0d addr 100",
               read_cyc.size(), (read_cyc.size() > 0) ? read_cyc[0] : -1, start_cyc + 1);
    end
    n_checks++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== start_cyc + 6 || done_busy_viol !== 0) begin
      n_fail++;
      $display("FAIL basic_done_cycle: got n=%0d cyc=%0d busyviol=%0d expected 1 %0d 0",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1,
               done_busy_viol, start_cyc + 6);
    end
    $display("test_basic_burst done: %0d words", obs_data.size());
  endtask

  task automatic test_backpressure();
    bit ok;
    ready_mode = 1;
    rdy_idx    = 0;
    clear_obs();
    build_expected(32'h100, 4);
    pulse_start(32'h100, 4);
    wait_done(ok);
    wait_cycle();
    ready_mode = 0;
    n_checks++;
    if (!ok || obs_data.size() !== 4) begin
      n_fail++;
      $display("FAIL bp_count: got ok=%b n=%0d expected ok=1 n=4", ok, obs_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
        n_fail++;
        $display("FAIL bp_word%0d: got %h/%b expected %h/%b",
                 i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
      end
    end
    n_checks++;
    if (stall_viol !== 0 || full_read_viol !== 0) begin
      n_fail++;
      $display("FAIL bp_stall: got stall_viol=%0d full_read_viol=%0d expected 0 0",
               stall_viol, full_read_viol);
    end
    n_checks++;
    if (done_cyc.size() !== 1 || obs_cyc.size() == 0 ||
        done_cyc[0] !== obs_cyc[obs_cyc.size() - 1] + 1) begin
      n_fail++;
      $display("FAIL bp_done: got n=%0d expected 1 done right after last transfer",
               done_cyc.size());
    end
    $display("test_backpressure done: %0d words", obs_data.size());
  endtask

  task automatic test_wrap();
    bit ok;
    ready_mode = 0;
    clear_obs();
    build_expected(32'h3FC, 2);
    pulse_start(32'h3FC, 2);
    wait_done(ok);
    wait_cycle();
    n_checks++;
    if (!ok || obs_addr.size() !== 2) begin
      n_fail++;
      $display("FAIL wrap_reads: got ok=%b n=%0d expected ok=1 n=2", ok, obs_addr.size());
    end else begin
      n_checks++;
      if (obs_addr[0] !== 10'h3FC || obs_addr[1] !== 10'h000) begin
        n_fail++;
        $display("FAIL wrap_addr: got %h %h expected 3fc 000", obs_addr[0], obs_addr[1]);
      end
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
        n_fail++;
        $display("FAIL wrap_word%0d: got %h/%b expected %h/%b",
                 i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
      end
    end
    $display("test_wrap done");
  endtask

  task automatic test_unaligned_and_zero();
    bit ok;
    ready_mode = 0;
    clear_obs();
    pulse_start(32'h103, 1);
    wait_done(ok);
    wait_cycle();
    n_checks++;
    if (!ok || obs_addr.size() !== 1 || obs_data.size() !== 1) begin
      n_fail++;
      $display("FAIL unaligned_count: got ok=%b reads=%0d words=%0d expected 1 1 1",
               ok, obs_addr.size(), obs_data.size());
    end else begin
      n_checks++;
      if (obs_addr[0] !== 10'h100 || obs_data[0] !== 32'h11111111 || obs_last[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL unaligned_word: got addr=%h data=%h last=%b expected 100 11111111 1",
                 obs_addr[0], obs_data[0], obs_last[0]);
      end
    end
    clear_obs();
    pulse_start(32'h055, 0);
    wait_done(ok);
    wait_cycle();
    wait_cycle();
    n_checks++;
    if (!ok || done_cyc.size() !== 1 || done_cyc[0] !== start_cyc + 1) begin
      n_fail++;
      $display("FAIL zero_done: got ok=%b n=%0d cyc=%0d expected 1 1 %0d", ok,
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, start_cyc + 1);
    end
    n_checks++;
    if (valid_cnt !== 0 || obs_addr.size() !== 0 || done_busy_viol !== 0) begin
      n_fail++;
      $display("FAIL zero_activity: got valid=%0d reads=%0d busyviol=%0d expected 0 0 0",
               valid_cnt, obs_addr.size(), done_busy_viol);
    end
    $display("test_unaligned_and_zero done");
  endtask

  task automatic test_start_while_busy();
    bit ok;
    ready_mode = 1;
    rdy_idx    = 0;
    clear_obs();
    build_expected(32'h080, 6);
    pulse_start(32'h080, 6);
    wait_cycle();
    wait_cycle();
    pulse_start(32'h300, 3);
    wait_done(ok);
    repeat (4) wait_cycle();
    ready_mode = 0;
    n_checks++;
    if (!ok || obs_data.size() !== 6 || done_cyc.size() !== 1) begin
      n_fail++;
      $display("FAIL busy_start_count: got ok=%b words=%0d dones=%0d expected 1 6 1",
               ok, obs_data.size(), done_cyc.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i] ||
          obs_addr[i] !== exp_addr[i]) begin
        n_fail++;
        $display("FAIL busy_start_word%0d: got %h/%b@%h expected %h/%b@%h", i,
                 obs_data[i], obs_last[i], obs_addr[i], exp_data[i], exp_last[i], exp_addr[i]);
      end
    end
    $display("test_start_while_busy done");
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    ready_mode = 0;
    clear_obs();
    pulse_start(32'h200, 8);
    wait_cycle();
    wait_cycle();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, bus.mem_read, bus.out_valid, bus.out_last} !== 5'b0 ||
        bus.mem_address !== '0 || bus.out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got flags=%b addr=%h data=%h expected 00000 000 00000000",
               {busy, done, bus.mem_read, bus.out_valid, bus.out_last},
               bus.mem_address, bus.out_data);
    end
    wait_cycle();
    wait_cycle();
    reset_n = 1'b1;
    wait_cycle();
    clear_obs();
    repeat (10) wait_cycle();
    n_checks++;
    if (done_cyc.size() !== 0 || valid_cnt !== 0 || obs_addr.size() !== 0) begin
      n_fail++;
      $display("FAIL midreset_quiet: got dones=%0d valid=%0d reads=%0d expected 0 0 0",
               done_cyc.size(), valid_cnt, obs_addr.size());
    end
    clear_obs();
    build_expected(32'h040, 3);
    pulse_start(32'h040, 3);
    wait_done(ok);
    wait_cycle();
    n_checks++;
    if (!ok || obs_data.size() !== 3) begin
      n_fail++;
      $display("FAIL midreset_restart: got ok=%b n=%0d expected 1 3", ok, obs_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i] ||
          obs_addr[i] !== exp_addr[i]) begin
        n_fail++;
        $display("FAIL midreset_word%0d: got %h/%b@%h expected %h/%b@%h", i,
                 obs_data[i], obs_last[i], obs_addr[i], exp_data[i], exp_last[i], exp_addr[i]);
      end
    end
    $display("test_reset_mid_burst done");
  endtask

  task automatic test_random_bursts();
    bit ok;
    for (int t = 0; t < 12; t++) begin
      int base;
      int count;
      int exp_done;
      base  = int'($urandom_range(0, MEM_SIZE - 1));
      count = int'($urandom_range(0, 10));
      ready_mode = ($urandom_range(0, 3) == 0) ? 0 : 2;
      clear_obs();
      build_expected(base, count);
      pulse_start(base, count);
      wait_done(ok);
      wait_cycle();
      n_checks++;
      if (!ok || obs_data.size() !== count || obs_addr.size() !== count) begin
        n_fail++;
        $display("FAIL rand%0d_count: got ok=%b words=%0d reads=%0d expected 1 %0d %0d",
                 t, ok, obs_data.size(), obs_addr.size(), count, count);
      end
      for (int i = 0; i < count && i < obs_data.size() && i < obs_addr.size(); i++) begin
        n_checks++;
        if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i] ||
            obs_addr[i] !== exp_addr[i]) begin
          n_fail++;
          $display("FAIL rand%0d_word%0d: got %h/%b@%h expected %h/%b@%h", t, i,
                   obs_data[i], obs_last[i], obs_addr[i], exp_data[i], exp_last[i], exp_addr[i]);
        end
      end
      exp_done = (count == 0 || obs_cyc.size() == 0) ? start_cyc + 1
                                                     : obs_cyc[obs_cyc.size() - 1] + 1;
      n_checks++;
      if (done_cyc.size() !== 1 || done_cyc[0] !== exp_done || done_busy_viol !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_done: got n=%0d cyc=%0d busyviol=%0d expected 1 %0d 0", t,
                 done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1,
                 done_busy_viol, exp_done);
      end
      n_checks++;
      if (stall_viol !== 0 || full_read_viol !== 0 ||
          (count > 0 && (read_cyc.size() == 0 || read_cyc[0] !== start_cyc + 1))) begin
        n_fail++;
        $display("FAIL rand%0d_flow: got stall_viol=%0d full_read_viol=%0d expected 0 0 and first read at %0d",
                 t, stall_viol, full_read_viol, start_cyc + 1);
      end
      $display("rand burst %0d: base=%h count=%0d words=%0d", t, base, count, obs_data.size());
    end
    ready_mode = 0;
  endtask

  initial begin
    for (int i = 0; i < MEM_SIZE / 4; i++) mem_words[i] = $urandom;
    mem_words[32'h100 / 4 + 0] = 32'h11111111;
    mem_words[32'h100 / 4 + 1] = 32'h22222222;
    mem_words[32'h100 / 4 + 2] = 32'h33333333;
    mem_words[32'h100 / 4 + 3] = 32'h44444444;
    clear_obs();
    test_reset();
    test_basic_burst();
    test_backpressure();
    test_wrap();
    test_unaligned_and_zero();
    test_start_while_busy();
    test_reset_mid_burst();
    test_random_bursts();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning byte-address width of the data memory.
REQ-002 The block SHALL have parameter CNT_W, default 9, meaning word-count width (max 256 words, full 1 KiB memory).
REQ-003 Clocking SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-004 Port: clk  input  1  sole clock, all state on rising edge.
REQ-005 Port: reset_n  input  1  asynchronous active-low reset.
REQ-006 Port: start  input  1  one-cycle request to begin a burst; ignored while busy.
REQ-007 Port: base_addr  input  ADDR_W  byte address of first word, sampled on accepted start.
REQ-008 Port: word_count  input  CNT_W  number of 32-bit words, sampled on accepted start.
REQ-009 Port: busy  output  1  burst in progress.
REQ-010 Port: done  output  1  one-cycle pulse at burst completion.
REQ-011 Port: mem_address  output  ADDR_W  byte address to data memory.
REQ-012 Port: mem_read  output  1  read enable to data memory.
REQ-013 Port: mem_readdata  input  32  combinational little-endian word returned by data memory in the same cycle as mem_read.
REQ-014 Port: out_valid / out_ready  output / input  1  stream handshake; transfer when both high.
REQ-015 Port: out_data  output  32  streamed word.
REQ-016 Port: out_last  output  1  high with the final word of a burst.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, DRAIN; start with busy low moves IDLE->FETCH (word_count>0) or IDLE->DRAIN (word_count==0).
REQ-018 base_addr[1:0] SHALL be forced to 00 on capture (word alignment).
REQ-019 In FETCH, mem_read SHALL be high exactly when the 2-entry output FIFO has a free slot or is popped this cycle; mem_readdata SHALL be pushed on that edge.
REQ-020 Address of word i SHALL be aligned base + 4*i modulo 2^ADDR_W (wraps 1020->0).
REQ-021 mem_read SHALL be low in IDLE and DRAIN; mem_address SHALL hold its last value when mem_read is low.
REQ-022 After the last read is issued FETCH SHALL go to DRAIN; DRAIN SHALL go to IDLE when FIFO is empty and no pop is pending.
REQ-023 Latency: start at cycle 0 -> first mem_read cycle 1 -> out_valid cycle 2; sustained throughput 1 word/cycle with out_ready high.
REQ-024 out_data/out_last SHALL stay stable while out_valid high and out_ready low.
REQ-025 out_last SHALL be high only on the entry holding word word_count-1.
REQ-026 done SHALL pulse in the cycle after the transfer with out_last, or the cycle after start for word_count 0; busy SHALL fall in that same cycle.
REQ-027 start while busy SHALL be ignored with no change to captured base/count.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, FIFO empty, busy=0, done=0, mem_read=0, mem_address=0, out_valid=0, out_last=0, out_data=0.
REQ-029 Reset mid-burst SHALL discard all buffered words; no done pulse follows.

Structure
REQ-030 FSM state encoding and ADDR_W/CNT_W defaults SHALL reside in shared package cnn_mem_pkg.
REQ-031 The output buffer SHALL be one sub-module, stream_fifo2 (2-entry, push/pop/full/empty, 32+1 bits wide).

Verification
REQ-032 Memory words 0x11111111..0x44444444 at 0x100..0x10C, start base 0x100 count 4, out_ready=1 -> four words on cycles 2-5, out_last on 0x44444444, done cycle 6.
REQ-033 Same burst, out_ready toggled 1,0,0,1,... -> no word lost/duplicated, out_data stable while stalled, mem_read low when FIFO full.
REQ-034 base 0x3FC count 2 -> addresses 0x3FC then 0x000.
REQ-035 base 0x103 count 1 -> mem_address 0x100; word_count 0 -> done cycle 1, no out_valid.
REQ-036 reset_n low on cycle 3 of 8-word burst -> all outputs zero at once; new start after release streams from word 0.
